// File: rtl/taillight_pkg.sv
// Shared types and helpers for the taillight sequencer.
package taillight_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE  = 2'd0,
        MODE_LEFT  = 2'd1,
        MODE_RIGHT = 2'd2,
        MODE_HAZ   = 2'd3
    } mode_e;

    // Ramp brightness of lamp idx at animation step: clamp(step-idx, 0, maxlvl).
    function automatic int lvl_of(input int step, input int idx, input int maxlvl);
        int d;
        d = step - idx;
        if (d < 0) return 0;
        if (d > maxlvl) return maxlvl;
        return d;
    endfunction

endpackage

// File: rtl/taillight_seq_lamp_pwm.sv
// Per-lamp PWM stage: compares a brightness level against the shared PWM count.
module lamp_pwm #(
    parameter int LVL_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [LVL_W-1:0] lvl,
    input  logic [LVL_W-1:0] pwm_cnt,
    output logic             lamp
);

    // Level 0 must stay dark even though pwm_cnt==0 satisfies the compare.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) lamp <= 1'b0;
        else       lamp <= (lvl != '0) && (pwm_cnt <= lvl);
    end

endmodule

// File: rtl/taillight_seq.sv
// Turn/hazard taillight controller: mode FSM, step timer, level register and PWM lamps.
module taillight_seq
    import taillight_pkg::*;
#(
    parameter int LAMPS    = 3,
    parameter int LVL_W    = 2,
    parameter int STEP_DIV = 25_000_000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   left,
    input  logic                   right,
    input  logic                   haz,
    output logic [LAMPS*LVL_W-1:0] lvl_l,
    output logic [LAMPS*LVL_W-1:0] lvl_r,
    output logic [LAMPS-1:0]       lamp_l,
    output logic [LAMPS-1:0]       lamp_r,
    output logic [1:0]             mode
);

    localparam int MAXLVL = (1 << LVL_W) - 1;
    localparam int NSTEP  = LAMPS + MAXLVL - 1;
    localparam int SW     = $clog2(NSTEP + 1);
    localparam int TW     = $clog2(STEP_DIV);

    mode_e                        mode_q, mode_d;
    logic [SW-1:0]                step_q, step_d;
    logic [TW-1:0]                tmr_q, tmr_d;
    logic [LVL_W-1:0]             pwm_cnt;
    logic [LAMPS-1:0][LVL_W-1:0]  lvl_l_q, lvl_r_q, lvl_l_d, lvl_r_d;
    logic                         req_haz, tick;

    assign req_haz = haz | (left & right);
    assign tick    = (mode_q != MODE_IDLE) && (tmr_q == TW'(STEP_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q  <= MODE_IDLE;
            step_q  <= '0;
            tmr_q   <= '0;
            pwm_cnt <= '0;
            lvl_l_q <= '0;
            lvl_r_q <= '0;
        end else begin
            mode_q  <= mode_d;
            step_q  <= step_d;
            tmr_q   <= tmr_d;
            pwm_cnt <= pwm_cnt + 1'b1;
            lvl_l_q <= lvl_l_d;
            lvl_r_q <= lvl_r_d;
        end
    end

    always_comb begin
        mode_d = mode_q;
        step_d = step_q;
        tmr_d  = (mode_q == MODE_IDLE || tick) ? '0 : tmr_q + 1'b1;
        case (mode_q)
            MODE_IDLE: begin
                if (req_haz)    begin mode_d = MODE_HAZ;   step_d = SW'(1); end
                else if (left)  begin mode_d = MODE_LEFT;  step_d = SW'(1); end
                else if (right) begin mode_d = MODE_RIGHT; step_d = SW'(1); end
            end
            MODE_LEFT, MODE_RIGHT: begin
                if (tick) begin
                    if (req_haz) begin
                        mode_d = MODE_HAZ; step_d = SW'(1);
                    end else if ((mode_q == MODE_LEFT && left) || (mode_q == MODE_RIGHT && right)) begin
                        step_d = (step_q == SW'(NSTEP)) ? '0 : step_q + 1'b1;
                    end else if (left || right) begin
                        mode_d = left ? MODE_LEFT : MODE_RIGHT; step_d = SW'(1);
                    end else begin
                        mode_d = MODE_IDLE; step_d = '0;
                    end
                end
            end
            MODE_HAZ: begin
                if (tick) begin
                    if (req_haz)    step_d = (step_q == '0) ? SW'(1) : '0;
                    else if (left)  begin mode_d = MODE_LEFT;  step_d = SW'(1); end
                    else if (right) begin mode_d = MODE_RIGHT; step_d = SW'(1); end
                    else            begin mode_d = MODE_IDLE;  step_d = '0; end
                end
            end
            default: begin
                mode_d = MODE_IDLE;
                step_d = '0;
            end
        endcase
    end

    // Levels are derived from the next mode/step so they land on the same edge.
    always_comb begin
        lvl_l_d = '0;
        lvl_r_d = '0;
        case (mode_d)
            MODE_LEFT:
                for (int i = 0; i < LAMPS; i++)
                    lvl_l_d[i] = LVL_W'(lvl_of(int'(step_d), i, MAXLVL));
            MODE_RIGHT:
                for (int i = 0; i < LAMPS; i++)
                    lvl_r_d[i] = LVL_W'(lvl_of(int'(step_d), i, MAXLVL));
            MODE_HAZ:
                if (step_d != '0) begin
                    for (int i = 0; i < LAMPS; i++) begin
                        lvl_l_d[i] = LVL_W'(MAXLVL);
                        lvl_r_d[i] = LVL_W'(MAXLVL);
                    end
                end
            default: ;
        endcase
    end

    for (genvar g = 0; g < LAMPS; g++) begin : g_lamp
        lamp_pwm #(.LVL_W(LVL_W)) u_pwm_l (
            .clk(clk), .reset(reset), .lvl(lvl_l_q[g]), .pwm_cnt(pwm_cnt), .lamp(lamp_l[g])
        );
        lamp_pwm #(.LVL_W(LVL_W)) u_pwm_r (
            .clk(clk), .reset(reset), .lvl(lvl_r_q[g]), .pwm_cnt(pwm_cnt), .lamp(lamp_r[g])
        );
    end

    assign lvl_l = lvl_l_q;
    assign lvl_r = lvl_r_q;
    assign mode  = mode_q;

endmodule

// File: tb/tb_taillight_seq.sv
// Bench for taillight_seq: directed vector table, corner sequences, random run vs. model.
module tb_taillight_seq;

    localparam int LAMPS = 3, LVL_W = 2, STEP_DIV = 4;
    localparam int MAXLVL = 3, NSTEP = LAMPS + MAXLVL - 1;

    logic clk = 0, reset = 0, l = 0, r = 0, h = 0;
    logic [5:0] lvl_l, lvl_r;
    logic [2:0] lamp_l, lamp_r;
    logic [1:0] mode;

    taillight_seq #(.LAMPS(LAMPS), .LVL_W(LVL_W), .STEP_DIV(STEP_DIV)) dut (
        .clk(clk), .reset(reset), .left(l), .right(r), .haz(h),
        .lvl_l(lvl_l), .lvl_r(lvl_r), .lamp_l(lamp_l), .lamp_r(lamp_r), .mode(mode)
    );

    always #5 clk = ~clk;

    int nerr = 0, nchk = 0;

    // Reference model: mode (0 idle,1 left,2 right,3 haz), step, cycles into step.
    int mmode, mstep, mage, mpwm;
    int ml[3], mr[3];
    logic [2:0] mlamp_l, mlamp_r;

    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        mmode = 0; mstep = 0; mage = 0; mpwm = 0;
        mlamp_l = '0; mlamp_r = '0;
        for (int i = 0; i < 3; i++) begin ml[i] = 0; mr[i] = 0; end
    endtask

    task automatic model_edge();
        int want, v;
        bit tk;
        for (int i = 0; i < 3; i++) begin
            mlamp_l[i] = (ml[i] != 0) && (mpwm <= ml[i]);
            mlamp_r[i] = (mr[i] != 0) && (mpwm <= mr[i]);
        end
        mpwm = (mpwm + 1) % 4;
        want = (h || (l && r)) ? 3 : l ? 1 : r ? 2 : 0;
        tk = (mmode != 0) && (mage == STEP_DIV - 1);
        if (mmode == 0) begin
            if (want != 0) begin mmode = want; mstep = 1; end
            mage = 0;
        end else if (tk) begin
            mage = 0;
            if (want == mmode && mmode != 3) mstep = (mstep + 1) % (NSTEP + 1);
            else if (want == 3 && mmode == 3) mstep = 1 - mstep;
            else begin mmode = want; mstep = (want != 0) ? 1 : 0; end
        end else mage++;
        for (int i = 0; i < 3; i++) begin
            v = mstep - i;
            if (v < 0) v = 0;
            if (v > MAXLVL) v = MAXLVL;
            ml[i] = 0; mr[i] = 0;
            if (mmode == 1) ml[i] = v;
            if (mmode == 2) mr[i] = v;
            if (mmode == 3) begin ml[i] = mstep ? MAXLVL : 0; mr[i] = ml[i]; end
        end
    endtask

    task automatic chkall(input string tag);
        logic [5:0] el, er;
        for (int i = 0; i < 3; i++) begin
            el[2*i +: 2] = 2'(ml[i]);
            er[2*i +: 2] = 2'(mr[i]);
        end
        chk({tag, ".mode"}, mode, mmode);
        chk({tag, ".lvl_l"}, lvl_l, el);
        chk({tag, ".lvl_r"}, lvl_r, er);
        chk({tag, ".lamp_l"}, lamp_l, mlamp_l);
        chk({tag, ".lamp_r"}, lamp_r, mlamp_r);
    endtask

    task automatic cycle();
        @(posedge clk);
        if (reset) model_reset(); else model_edge();
        #1;
        chkall("model");
    endtask

    task automatic do_reset();
        reset = 1;
        #1;
        model_reset();
        chkall("rst");
        cycle();
        reset = 0;
    endtask

    typedef struct {
        logic rst, left, right, haz;
        int n, m;
        logic [5:0] el, er;
    } vec_t;
    vec_t tbl[$];

    initial begin
        int cnt;
        // left ramp
        tbl.push_back('{1, 1, 0, 0, 1, 1, 6'b000001, 6'b0});
        tbl.push_back('{0, 1, 0, 0, 4, 1, 6'b000110, 6'b0});
        tbl.push_back('{0, 1, 0, 0, 4, 1, 6'b011011, 6'b0});
        tbl.push_back('{0, 1, 0, 0, 4, 1, 6'b101111, 6'b0});
        tbl.push_back('{0, 1, 0, 0, 4, 1, 6'b111111, 6'b0});
        tbl.push_back('{0, 1, 0, 0, 4, 1, 6'b000000, 6'b0});
        tbl.push_back('{0, 1, 0, 0, 4, 1, 6'b000001, 6'b0});
        // left+right from idle means hazard
        tbl.push_back('{1, 1, 1, 0, 1, 3, 6'b111111, 6'b111111});
        tbl.push_back('{0, 1, 1, 0, 4, 3, 6'b000000, 6'b000000});
        tbl.push_back('{0, 1, 1, 0, 4, 3, 6'b111111, 6'b111111});
        // right ramp start
        tbl.push_back('{1, 0, 1, 0, 1, 2, 6'b0, 6'b000001});
        tbl.push_back('{0, 0, 1, 0, 4, 2, 6'b0, 6'b000110});
        // right added mid-step: nothing until the tick
        tbl.push_back('{1, 1, 0, 0, 1, 1, 6'b000001, 6'b0});
        tbl.push_back('{0, 1, 0, 0, 2, 1, 6'b000001, 6'b0});
        tbl.push_back('{0, 1, 1, 0, 1, 1, 6'b000001, 6'b0});
        tbl.push_back('{0, 1, 1, 0, 1, 3, 6'b111111, 6'b111111});
        // left released at step 2
        tbl.push_back('{1, 1, 0, 0, 1, 1, 6'b000001, 6'b0});
        tbl.push_back('{0, 1, 0, 0, 4, 1, 6'b000110, 6'b0});
        tbl.push_back('{0, 0, 0, 0, 3, 1, 6'b000110, 6'b0});
        tbl.push_back('{0, 0, 0, 0, 1, 0, 6'b000000, 6'b0});
        tbl.push_back('{0, 0, 0, 0, 4, 0, 6'b000000, 6'b0});
        // haz input alone from idle
        tbl.push_back('{1, 0, 0, 1, 1, 3, 6'b111111, 6'b111111});

        do_reset();
        foreach (tbl[k]) begin
            if (tbl[k].rst) begin l = 0; r = 0; h = 0; do_reset(); end
            l = tbl[k].left; r = tbl[k].right; h = tbl[k].haz;
            repeat (tbl[k].n) cycle();
            chk($sformatf("vec%0d.mode", k), mode, tbl[k].m);
            chk($sformatf("vec%0d.lvl_l", k), lvl_l, tbl[k].el);
            chk($sformatf("vec%0d.lvl_r", k), lvl_r, tbl[k].er);
        end

        // PWM duty per level on the innermost lamp
        l = 0; r = 0; h = 0;
        do_reset();
        l = 1;
        cycle();
        for (int k = 0; k < 3; k++) begin
            cnt = 0;
            repeat (4) begin cycle(); cnt += int'(lamp_l[0]); end
            chk($sformatf("duty_lvl%0d", k + 1), cnt, k + 2);
        end

        // asynchronous reset mid-ramp at step 3
        do_reset();
        l = 1;
        repeat (9) cycle();
        chk("pre_rst.lvl_l", lvl_l, 6'b011011);
        #3 reset = 1;
        #1;
        chk("async_rst.lvl_l", lvl_l, 0);
        chk("async_rst.lamp_l", lamp_l, 0);
        chk("async_rst.mode", mode, 0);
        model_reset();
        cycle();
        reset = 0; l = 0;
        repeat (6) begin
            cycle();
            chk("post_rst.lvl_l", lvl_l, 0);
        end

        // randomized run against the model
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 9) == 0) begin
                l = 1'($urandom_range(0, 1));
                r = 1'($urandom_range(0, 1));
                h = ($urandom_range(0, 4) == 0);
            end
            if ($urandom_range(0, 299) == 0) do_reset();
            else cycle();
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
